mult_error_profiler: RTL

MULT_ERROR_PROFILER -- requirements
Module: mult_error_profiler

---
 rtl/mult_error_profiler_pkg.sv | 16 +
 rtl/mult_error_profiler_abs_diff.sv | 12 +
 rtl/mult_error_profiler.sv | 115 +++++++++++
 3 files changed

// File: rtl/mult_error_profiler_pkg.sv
// Shared types and widths for the multiplier error profiler.
package mult_error_profiler_pkg;

    localparam int W_DEF  = 4;
    localparam int PROD_W = 2 * W_DEF;
    localparam int CNT_W  = 2 * W_DEF + 1;
    localparam int SUM_W  = 4 * W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mult_error_profiler_abs_diff.sv
// Unsigned absolute difference |a - b|, purely combinational.
module abs_diff #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] d
);

    assign d = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/mult_error_profiler.sv
// Sweeps every operand pair through an external multiplier and profiles its
// error distance against the exact product (count, maximum, sum).
module mult_error_profiler
    import mult_error_profiler_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic [2*W-1:0]   mult_p,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     err_count,
    output logic [2*W-1:0]   max_ed,
    output logic [4*W-1:0]   sum_ed,
    output state_t           state_dbg
);

    localparam logic [2*W-1:0] IDX_ONE = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [2*W:0]   CNT_ONE = {{(2*W){1'b0}}, 1'b1};

    state_t           state;
    logic [2*W-1:0]   index;
    logic [2*W-1:0]   index_nx;
    logic [2*W-1:0]   exact;
    logic [2*W-1:0]   p_q;
    logic [2*W-1:0]   exact_q;
    logic [2*W-1:0]   ed;
    logic             s1_valid;

    assign index_nx  = index + IDX_ONE;
    assign exact     = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
    assign state_dbg = state;

    abs_diff #(.N(2*W)) u_abs_diff (
        .a (p_q),
        .b (exact_q),
        .d (ed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            index     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            p_q       <= '0;
            exact_q   <= '0;
            s1_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else begin
            // Stage 2 runs whenever stage 1 holds an entry, even on an abort edge.
            if (s1_valid) begin
                if (ed != '0) err_count <= err_count + CNT_ONE;
                sum_ed <= sum_ed + {{(2*W){1'b0}}, ed};
                if (ed > max_ed) max_ed <= ed;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_SWEEP;
                        index     <= '0;
                        op_a      <= '0;
                        op_b      <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err_count <= '0;
                        max_ed    <= '0;
                        sum_ed    <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        s1_valid <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        p_q      <= mult_p;
                        exact_q  <= exact;
                        s1_valid <= 1'b1;
                        index    <= index_nx;
                        // Operands follow the index but hold the final pair once it wraps.
                        if (&index) begin
                            state <= ST_DRAIN;
                        end else begin
                            op_a <= index_nx[W-1:0];
                            op_b <= index_nx[2*W-1:W];
                        end
                    end
                end
                ST_DRAIN: begin
                    s1_valid <= 1'b0;
                    busy     <= 1'b0;
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
